// File: rtl/serv_rf_ram_clr.sv
// serv_rf_ram_clr -- register-file storage stage for SERV.
//
// Holds the 32 GPRs plus csr_regs CSRs as a single-write/single-read RAM
// with a 1-cycle registered read port. After reset, or when i_clear is
// pulsed, a sequencer writes zero to every word, one word per cycle.
// o_init_done stays low until that sweep has finished.
//
// Ports:
//   i_clk        clock; all logic is rising-edge
//   i_rst_n      asynchronous active-low reset
//   i_clear      synchronous request to re-run the clear sweep
//   o_init_done  high once the array is cleared and the ports are live
//   i_waddr/i_wdata/i_wen   write port (ignored during the sweep)
//   i_raddr/i_ren           read port (ignored during the sweep)
//   o_rdata      registered read data; holds its value while i_ren=0
//
// Optional feature: macro SERV_RF_RAM_PARITY_EN adds a stored even-parity
// bit per word, a sticky o_parity_err output and an i_inj_err test input.
module serv_rf_ram_clr #(
  parameter int width    = 8,
  parameter int csr_regs = 4,
  parameter int depth    = 32*(32+csr_regs)/width,
  parameter int aw       = $clog2(depth)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  output logic             o_init_done,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic             i_wen,
  input  logic [aw-1:0]    i_raddr,
  input  logic             i_ren,
`ifdef SERV_RF_RAM_PARITY_EN
  input  logic             i_inj_err,
  output logic             o_parity_err,
`endif
  output logic [width-1:0] o_rdata
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

`ifdef SERV_RF_RAM_PARITY_EN
  localparam int mw = width + 1;   // parity bit sits in the MSB
`else
  localparam int mw = width;
`endif

  localparam logic [aw-1:0] LAST    = aw'(depth - 1);
  localparam logic [aw:0]   DEPTH_C = (aw+1)'(depth);

  logic [mw-1:0] mem [0:depth-1];

  logic [0:0]       state_q, state_d;
  logic [aw-1:0]    cnt_q,   cnt_d;
  logic [width-1:0] rdata_q, rdata_d;
  logic             mem_we;
  logic [aw-1:0]    mem_wa;
  logic [mw-1:0]    mem_wd;
  logic             wr_ok, rd_ok;
  logic [mw-1:0]    rd_word;

  // Out-of-range addresses are never produced by the interface block; they
  // drop writes and read back as zero.
  assign wr_ok   = ({1'b0, i_waddr} < DEPTH_C);
  assign rd_ok   = ({1'b0, i_raddr} < DEPTH_C);
  assign rd_word = rd_ok ? mem[i_raddr] : '0;

`ifdef SERV_RF_RAM_PARITY_EN
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    mem_wa  = cnt_q;
    mem_wd  = '0;
`ifdef SERV_RF_RAM_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      CLEAR: begin
        // Sweep writes zero (and parity 0, which is consistent with zero).
        mem_we  = 1'b1;
        rdata_d = '0;
        if (i_clear) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          // Exit is decided before incrementing, so the counter never wraps.
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        mem_we = i_wen && wr_ok;
        mem_wa = i_waddr;
`ifdef SERV_RF_RAM_PARITY_EN
        mem_wd = {(^i_wdata) ^ i_inj_err, i_wdata};
`else
        mem_wd = i_wdata;
`endif
        // The array is read combinationally here and registered below, so a
        // same-address write in this cycle is not yet visible: old data wins.
        if (i_ren) begin
          rdata_d = rd_word[width-1:0];
`ifdef SERV_RF_RAM_PARITY_EN
          if (^rd_word) perr_d = 1'b1;
`endif
        end
        if (i_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
          rdata_d = '0;
        end
      end
    endcase
`ifdef SERV_RF_RAM_PARITY_EN
    if (i_clear) perr_d = 1'b0;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rdata_q <= '0;
`ifdef SERV_RF_RAM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef SERV_RF_RAM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Array has no reset; a write coinciding with reset assertion is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && mem_we) mem[mem_wa] <= mem_wd;
  end

  assign o_init_done = (state_q == RUN);
  assign o_rdata     = rdata_q;
`ifdef SERV_RF_RAM_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serv_rf_ram_clr.sv
// Directed bench for serv_rf_ram_clr (default parameters: 144 words of 8 bits).
module tb_serv_rf_ram_clr;
  localparam int W  = 8;
  localparam int D  = 144;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wen = 1'b0;
  logic          ren = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] raddr = '0;
  logic [W-1:0]  wdata = '0;
  logic          init_done;
  logic [W-1:0]  rdata;
`ifdef SERV_RF_RAM_PARITY_EN
  logic          inj = 1'b0;
  logic          perr;
`endif

  serv_rf_ram_clr dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clear     (clr),
    .o_init_done (init_done),
    .i_waddr     (waddr),
    .i_wdata     (wdata),
    .i_wen       (wen),
    .i_raddr     (raddr),
    .i_ren       (ren),
`ifdef SERV_RF_RAM_PARITY_EN
    .i_inj_err   (inj),
    .o_parity_err(perr),
`endif
    .o_rdata     (rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int leak  = 0;

  typedef struct {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wen = 1'b0; ren = 1'b0; clr = 1'b0;
  endtask

  // Count edges until o_init_done rises; tally any nonzero read data seen
  // while the sweep is still in progress.
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
      if (!init_done && rdata != '0) leak++;
    end while (!init_done && n < 400);
    check(nm, n, D);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    wen = 1'b1; waddr = a; wdata = d; ren = 1'b0;
    tick();
    idle();
  endtask

  task automatic rd(input string nm, input logic [AW-1:0] a, input logic [W-1:0] exp);
    ren = 1'b1; raddr = a; wen = 1'b0;
    tick();
    idle();
    check(nm, rdata, exp);
  endtask

  initial begin
    // --- reset state ---
    #12;
    check("reset init_done", init_done, 0);
    check("reset rdata", rdata, 0);
    #4 rst_n = 1'b1;              // 1 unit after a rising edge
    wait_done("first sweep length");

    // --- every word reads back zero ---
    begin
      int nz;
      nz = 0;
      for (int a = 0; a < D; a++) begin
        ren = 1'b1; raddr = AW'(a);
        tick();
        if (rdata != '0) nz++;
      end
      idle();
      check("all words zero after sweep", nz, 0);
    end

    // --- table of run-mode transactions; exp is o_rdata after the edge ---
    vt.push_back('{1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 8'h00});
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'hA5});
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'hA5});
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'hA5});
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'hA5});
    vt.push_back('{1'b1, 8'h20, 8'h3C, 1'b1, 8'h20, 8'h00}); // read-before-write
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 8'h3C});
    vt.push_back('{1'b1, 8'h8F, 8'hFF, 1'b1, 8'h10, 8'hA5}); // last word
    vt.push_back('{1'b1, 8'h00, 8'h66, 1'b1, 8'h8F, 8'hFF}); // first word
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h66});
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 8'hA0, 8'h00}); // out of range
    vt.push_back('{1'b1, 8'h90, 8'h77, 1'b1, 8'h20, 8'h3C}); // dropped write
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 8'h90, 8'h00});
    vt.push_back('{1'b1, 8'h20, 8'hC3, 1'b0, 8'h00, 8'h00}); // overwrite
    vt.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 8'hC3});
    foreach (vt[i]) begin
      wen = vt[i].wen; waddr = vt[i].waddr; wdata = vt[i].wdata;
      ren = vt[i].ren; raddr = vt[i].raddr;
      tick();
      check($sformatf("vec%0d rdata", i), rdata, vt[i].exp);
    end
    idle();
    check("init_done in run", init_done, 1);

    // --- i_clear re-sweeps; writes and reads ignored meanwhile ---
    wr(8'h05, 8'hFF);
    rd("pre-clear read 05", 8'h05, 8'hFF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clear drops init_done", init_done, 0);
    check("clear zeroes rdata", rdata, 0);
    wen = 1'b1; waddr = 8'h05; wdata = 8'h11;
    ren = 1'b1; raddr = 8'h10;
    leak = 0;
    wait_done("clear sweep length");
    idle();
    check("rdata held 0 during sweep", leak, 0);
    rd("post-clear read 05", 8'h05, 8'h00);
    rd("post-clear read 10", 8'h10, 8'h00);
    rd("post-clear read 8F", 8'h8F, 8'h00);

    // --- i_clear during a sweep restarts it ---
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (50) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    wait_done("restarted sweep length");

    // --- async reset at counter 70 ---
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (70) tick();
    #2 rst_n = 1'b0;
    #1;
    check("reset mid-sweep init_done", init_done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_done("sweep after mid-sweep reset");

    // --- async reset in run with live read data ---
    wr(8'h30, 8'h5A);
    rd("read 30", 8'h30, 8'h5A);
    #2 rst_n = 1'b0;
    #1;
    check("reset mid-run rdata", rdata, 0);
    check("reset mid-run init_done", init_done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_done("sweep after mid-run reset");
    rd("read 30 after reset", 8'h30, 8'h00);

`ifdef SERV_RF_RAM_PARITY_EN
    rd("clean read 07", 8'h07, 8'h00);
    check("parity clean", perr, 0);
    inj = 1'b1;
    wr(8'h07, 8'h01);
    inj = 1'b0;
    rd("corrupt read 07", 8'h07, 8'h01);
    check("parity error flagged", perr, 1);
    rd("clean read 08", 8'h08, 8'h00);
    check("parity error sticky", perr, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("parity cleared", perr, 0);
    wait_done("parity sweep length");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
